apb_rr_master_arbiter: RTL and testbench
========================================

Name: apb_rr_master_arbiter

Overview:
Shares one APB master port between NUM_REQ on-chip requesters, e.g. the AXI-to-APB bridge path and a debug/config master. Each requester presents a simple single-beat request. The block arbitrates round-robin and sequences the APB SETUP/ACCESS phases. It returns read data or an error to the granted requester, with a watchdog that terminates stalled transfers.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
APB_ADDR_WIDTH, 32, APB address width
APB_DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 256, max ACCESS cycles before forced error; 0 disables timeout

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accepted (one-hot or zero)
req_write_i  in  NUM_REQ  1 = write, 0 = read
req_addr_i  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
req_wdata_i  in  NUM_REQ*APB_DATA_WIDTH  packed write data
rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata_o  out  APB_DATA_WIDTH  read data, valid with any rsp_valid_o bit
rsp_err_o  out  1  error flag, valid with any rsp_valid_o bit
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  APB_DATA_WIDTH  APB write data
prdata_i  in  APB_DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Reset (rst_i high at an edge): all outputs 0. FSM to IDLE. RR pointer to 0. Timeout counter 0. Latched request cleared. Any in-flight transfer is abandoned with no rsp_valid_o. psel_o/penable_o are low in the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid_i is set, pick the winner g = first set bit searching from pointer upward, with wrap-around.
  - req_ready_o[g] = 1, combinational, in that same cycle. Only in IDLE, and only for g.
  - At the edge: latch write/addr/wdata of g and the grant index, set pointer = (g+1) mod NUM_REQ, go to SETUP.
  - No valid: stay in IDLE, pointer unchanged.
- SETUP: psel_o=1, penable_o=0. paddr_o/pwrite_o/pwdata_o driven from latch. Unconditional move to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1, same address/data held stable.
  - On pready_i=1: register rsp_rdata_o = prdata_i for reads (0 for writes) and rsp_err_o = pslverr_i. Pulse rsp_valid_o[grant] for exactly the next cycle, go to IDLE.
  - Timeout counter increments every ACCESS cycle without pready_i. When it reaches TIMEOUT_CYCLES, the transfer ends as if pready arrived: rsp_err_o=1, rsp_rdata_o=0. Counter clears on leaving ACCESS.
  - pready_i on the same cycle the counter hits its limit: pready wins, normal completion.
- Outputs outside SETUP/ACCESS:
  - psel_o=0, penable_o=0. paddr_o/pwrite_o/pwdata_o hold the last latched values.
  - rsp_rdata_o/rsp_err_o hold their values; meaningful only when rsp_valid_o is set.
- Latency and throughput:
  - Accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid_o at 3 with zero wait states.
  - The FSM is in IDLE at cycle 3 and may accept the next request that same cycle, so the minimum issue interval is 3 cycles.
- Requester rules:
  - Requesters hold valid and payload stable until ready. Dropping valid before ready is allowed; that requester is simply not chosen.
  - Requesters cannot back-pressure rsp_valid_o.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,…. A requester waits at most NUM_REQ-1 transfers.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). With TIMEOUT_CYCLES=0 the block waits indefinitely.

Test Plan:
- Single read: req 1 valid, addr 0x1000_0040. Slave pready=1 immediately with prdata 0xDEAD_BEEF. Expected: ready_o[1] at cycle 0, psel at cycles 1-2, penable at cycle 2, rsp_valid_o=4'b0010 at cycle 3 with rdata 0xDEAD_BEEF, err=0.
- Contention: all 4 requesters valid continuously with zero-wait slave. Expected: grant order 0,1,2,3,0, one grant every 3 cycles, paddr matches the granted requester each time.
- Wait states and write: req 2 writes 0x0000_00A5 to 0x20. pready is low for 5 ACCESS cycles. Expected: pwdata/paddr/pwrite stable throughout, rsp_valid_o[2] one cycle after pready, rdata=0, err=0.
- Slave error and timeout:
  - pslverr=1 with pready: expect rsp_err_o=1.
  - Separate run with TIMEOUT_CYCLES=8 and pready never asserted: expect psel to drop after 8 ACCESS cycles, rsp_valid pulse with err=1, rdata=0.
- Reset mid-ACCESS: assert rst_i in the 2nd ACCESS cycle. Expected: psel/penable=0 the next cycle, no rsp_valid_o, a subsequent grant goes to requester 0 first when all requesters are valid.

Source files
------------

// File: rtl/apb_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_master_arbiter
//
// Shares one APB master port between NUM_REQ single-beat requesters.
// Arbitration is round-robin: the search for a winner starts at the requester
// after the one granted last. The APB SETUP/ACCESS phases are sequenced here.
// A watchdog can end an ACCESS phase that the slave never completes.
//
// Parameters
//   NUM_REQ         number of requesters (>= 2)
//   APB_ADDR_WIDTH  APB address width
//   APB_DATA_WIDTH  APB data width
//   TIMEOUT_CYCLES  max ACCESS cycles before a forced error, 0 = wait forever
//
// Ports
//   clk_i, rst_i     clock (rising edge), synchronous active-high reset
//   req_valid_i      per-requester request valid
//   req_ready_o      per-requester accept strobe (one-hot or zero, IDLE only)
//   req_write_i      per-requester direction, 1 = write
//   req_addr_i       packed addresses, requester i at [i*AW +: AW]
//   req_wdata_i      packed write data, requester i at [i*DW +: DW]
//   rsp_valid_o      one-cycle completion pulse to the owning requester
//   rsp_rdata_o      read data (0 for writes / timeouts), valid with rsp_valid_o
//   rsp_err_o        error flag (slave error or timeout), valid with rsp_valid_o
//   psel_o .. pwdata_o  APB master outputs
//   prdata_i, pready_i, pslverr_i  APB slave responses
// -----------------------------------------------------------------------------
module apb_rr_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0]                  req_write_i,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                psel_o,
  output logic                                penable_o,
  output logic                                pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]           prdata_i,
  input  logic                                pready_i,
  input  logic                                pslverr_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // A zero-width counter is illegal, so the disabled-watchdog case keeps one
  // (unused) bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The watchdog fires in the ACCESS cycle whose counter value is one short
  // of the limit, i.e. exactly TIMEOUT_CYCLES ACCESS cycles are spent.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic [IDX_W-1:0]          ptr_reg, ptr_next;
  logic [IDX_W-1:0]          grant_reg, grant_next;
  logic                      write_reg, write_next;
  logic [APB_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [APB_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]        rsp_valid_reg, rsp_valid_next;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                      rsp_err_reg, rsp_err_next;

  // Unpacked views of the packed request payloads.
  logic [APB_ADDR_WIDTH-1:0] req_addr_arr  [NUM_REQ];
  logic [APB_DATA_WIDTH-1:0] req_wdata_arr [NUM_REQ];

  // Round-robin search results.
  logic [IDX_W-1:0]          win_idx;
  logic                      win_found;
  logic                      accept;
  logic                      timeout_hit;
  logic                      access_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr_arr[gi]  = req_addr_i[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
      assign req_wdata_arr[gi] = req_wdata_i[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Winner search: first valid requester at or after ptr_reg, wrapping around.
  // The candidate index is reduced by subtraction, so NUM_REQ need not be a
  // power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = ptr_reg;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && req_valid_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign accept = (state_reg == ST_IDLE) && win_found;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready_o[gi] = accept && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Watchdog: only armed when a limit is configured; a ready slave in the
  // same cycle takes precedence.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_reg == ST_ACCESS) &&
                       !pready_i && (cnt_reg == CNT_LAST);
  assign access_done = (state_reg == ST_ACCESS) && (pready_i || timeout_hit);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cnt_next       = '0;
    rsp_valid_next = '0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          grant_next = win_idx;
          write_next = req_write_i[win_idx];
          addr_next  = req_addr_arr[win_idx];
          wdata_next = req_wdata_arr[win_idx];
          ptr_next   = (win_idx == IDX_MAX) ? '0 : win_idx + IDX_W'(1);
          state_next = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_next = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (access_done) begin
          state_next                = ST_IDLE;
          rsp_valid_next[grant_reg] = 1'b1;
          if (pready_i) begin
            rsp_rdata_next = write_reg ? '0 : prdata_i;
            rsp_err_next   = pslverr_i;
          end else begin
            rsp_rdata_next = '0;
            rsp_err_next   = 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. Reset abandons any in-flight transfer without a response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // APB strobes decode straight from the state register; the payload comes
  // from the latch, which keeps its value while idle.
  assign psel_o      = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
  assign penable_o   = (state_reg == ST_ACCESS);
  assign pwrite_o    = write_reg;
  assign paddr_o     = addr_reg;
  assign pwdata_o    = wdata_reg;

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign rsp_err_o   = rsp_err_reg;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_master_arbiter
//
// Directed bench for apb_rr_master_arbiter with NUM_REQ=4 and a watchdog of
// 8 ACCESS cycles. Inputs change 2 time units after each rising edge; checks
// of combinational outputs follow 1 unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_apb_rr_master_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_rr_master_arbiter #(
    .NUM_REQ        (NR),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rr_addr(input int i);
    return 32'hA000_0000 + 32'(i * 16);
  endfunction

  task automatic show_rsp(input string name);
    $display("txn %s rsp_valid=%b rdata=%h err=%b", name, rsp_valid, rsp_rdata, rsp_err);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_psel",      32'(psel),      32'h0);
    check("rst_penable",   32'(penable),   32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_ready",     32'(req_ready), 32'h0);
    check("rst_paddr",     paddr,          32'h0);
    rst = 1'b0;

    // Single read from requester 1, zero wait states
    tick();
    req_valid          = 4'b0010;
    req_addr[1*AW +: AW] = 32'h1000_0040;
    pready             = 1'b1;
    prdata             = 32'hDEAD_BEEF;
    #1;
    check("rd_ready_c0", 32'(req_ready), 32'h2);
    check("rd_psel_c0",  32'(psel),      32'h0);
    tick();
    req_valid = '0;
    #1;
    check("rd_psel_c1",    32'(psel),      32'h1);
    check("rd_penable_c1", 32'(penable),   32'h0);
    check("rd_paddr_c1",   paddr,          32'h1000_0040);
    check("rd_pwrite_c1",  32'(pwrite),    32'h0);
    check("rd_ready_c1",   32'(req_ready), 32'h0);
    tick();
    check("rd_psel_c2",    32'(psel),    32'h1);
    check("rd_penable_c2", 32'(penable), 32'h1);
    tick();
    show_rsp("single_read");
    check("rd_rsp_valid_c3", 32'(rsp_valid), 32'h2);
    check("rd_rdata_c3",     rsp_rdata,      32'hDEAD_BEEF);
    check("rd_err_c3",       32'(rsp_err),   32'h0);
    check("rd_psel_c3",      32'(psel),      32'h0);
    tick();
    check("rd_rsp_valid_c4", 32'(rsp_valid), 32'h0);

    // Contention: fresh reset so the pointer starts at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = rr_addr(i);
    end
    req_valid = 4'b1111;
    pready    = 1'b1;
    prdata    = 32'h0000_0000;
    #1;
    for (int t = 0; t < 5; t++) begin
      int e;
      e = t % NR;
      check($sformatf("rr_ready_%0d", t), 32'(req_ready), 32'(1 << e));
      tick();
      check($sformatf("rr_paddr_%0d", t),   paddr,        rr_addr(e));
      check($sformatf("rr_penable_%0d", t), 32'(penable), 32'h0);
      tick();
      tick();
      show_rsp($sformatf("rr_grant_%0d", e));
      check($sformatf("rr_rsp_%0d", t), 32'(rsp_valid), 32'(1 << e));
    end
    req_valid = '0;
    #1;
    check("rr_ready_drop", 32'(req_ready), 32'h0);

    // Write from requester 2 with 5 wait states (pointer now at 1)
    tick();
    req_valid            = 4'b0100;
    req_write            = 4'b0100;
    req_addr[2*AW +: AW]  = 32'h0000_0020;
    req_wdata[2*DW +: DW] = 32'h0000_00A5;
    pready               = 1'b0;
    prdata               = 32'h1234_5678;
    #1;
    check("wr_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    req_write = '0;
    check("wr_setup_penable", 32'(penable), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wr_wait_pen_%0d", i),   32'(penable),   32'h1);
      check($sformatf("wr_wait_paddr_%0d", i), paddr,          32'h0000_0020);
      check($sformatf("wr_wait_wdata_%0d", i), pwdata,         32'h0000_00A5);
      check($sformatf("wr_wait_write_%0d", i), 32'(pwrite),    32'h1);
      check($sformatf("wr_wait_rsp_%0d", i),   32'(rsp_valid), 32'h0);
    end
    tick();
    pready = 1'b1;
    check("wr_last_penable", 32'(penable), 32'h1);
    check("wr_last_wdata",   pwdata,       32'h0000_00A5);
    tick();
    pready = 1'b0;
    show_rsp("write_wait");
    check("wr_rsp_valid", 32'(rsp_valid), 32'h4);
    check("wr_rdata",     rsp_rdata,      32'h0);
    check("wr_err",       32'(rsp_err),   32'h0);

    // Slave error on a read from requester 3 (pointer now at 3)
    req_valid            = 4'b1000;
    req_addr[3*AW +: AW] = 32'h0000_0030;
    pready               = 1'b1;
    pslverr              = 1'b1;
    prdata               = 32'hCAFE_0001;
    #1;
    check("se_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("se_paddr", paddr, 32'h0000_0030);
    tick();
    tick();
    pslverr = 1'b0;
    show_rsp("slverr");
    check("se_rsp_valid", 32'(rsp_valid), 32'h8);
    check("se_err",       32'(rsp_err),   32'h1);
    check("se_rdata",     rsp_rdata,      32'hCAFE_0001);

    // pready in the very cycle the watchdog would fire: normal completion
    req_valid            = 4'b0001;
    req_addr[0*AW +: AW] = 32'h0000_0040;
    pready               = 1'b0;
    prdata               = 32'h55AA_55AA;
    #1;
    check("lim_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("lim_psel_%0d", i), 32'(psel), 32'h1);
    end
    tick();
    pready = 1'b1;
    check("lim_psel_8",    32'(psel),    32'h1);
    check("lim_penable_8", 32'(penable), 32'h1);
    tick();
    pready = 1'b0;
    show_rsp("pready_at_limit");
    check("lim_rsp_valid", 32'(rsp_valid), 32'h1);
    check("lim_err",       32'(rsp_err),   32'h0);
    check("lim_rdata",     rsp_rdata,      32'h55AA_55AA);

    // Watchdog: slave never ready, 8 ACCESS cycles then forced error
    req_valid            = 4'b0010;
    req_addr[1*AW +: AW] = 32'h0000_0050;
    prdata               = 32'hFFFF_0000;
    #1;
    check("to_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("to_psel_%0d", i), 32'(psel),      32'h1);
      check($sformatf("to_rsp_%0d", i),  32'(rsp_valid), 32'h0);
    end
    tick();
    show_rsp("timeout");
    check("to_psel_drop",  32'(psel),      32'h0);
    check("to_rsp_valid",  32'(rsp_valid), 32'h2);
    check("to_err",        32'(rsp_err),   32'h1);
    check("to_rdata",      rsp_rdata,      32'h0);
    tick();
    check("to_rsp_clear",  32'(rsp_valid), 32'h0);

    // Reset in the 2nd ACCESS cycle (pointer now at 2)
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = rr_addr(i);
    end
    req_valid = 4'b1111;
    #1;
    check("mr_ready", 32'(req_ready), 32'h4);
    tick();
    tick();
    check("mr_access1", 32'(penable), 32'h1);
    tick();
    rst    = 1'b1;
    pready = 1'b1;
    tick();
    rst    = 1'b0;
    pready = 1'b0;
    check("mr_psel",      32'(psel),      32'h0);
    check("mr_penable",   32'(penable),   32'h0);
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    #1;
    check("mr_ready_after", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("mr_paddr",     paddr,          rr_addr(0));
    check("mr_rsp_quiet", 32'(rsp_valid), 32'h0);
    tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    show_rsp("after_reset");
    check("mr_rsp_grant0", 32'(rsp_valid), 32'h1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
